sat_accumulator: RTL and testbench

SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

---
 rtl/sat_accumulator.sv | 154 +++++++++++++++
 tb/tb_sat_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sat_accumulator.sv
// ---------------------------------------------------------------------------
// sat_accumulator
//
// Purpose:
//   Accepts N_SAMPLES operand beats (a, b) per frame and accumulates a+b into
//   an ACC_WIDTH-bit saturating accumulator. Once the last beat of a frame is
//   taken, the block holds the frame result on the output side until the
//   consumer takes it. Then it returns to idle and is ready for the next frame.
//
// Parameters:
//   WIDTH     - unsigned operand width
//   ACC_WIDTH - accumulator/result width, must be >= WIDTH+1
//   N_SAMPLES - beats per frame, 1..255
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand beat present
//   in_ready   out  block can accept a beat (depends on state only)
//   in_a       in   operand A [WIDTH]
//   in_b       in   operand B [WIDTH]
//   out_valid  out  frame result present
//   out_ready  in   consumer takes result
//   out_sum    out  saturated frame sum [ACC_WIDTH]
//   out_sat    out  a clamp happened somewhere in this frame
//   ovf_sticky out  (SAT_ACC_STICKY_OVF_EN only) any clamp since reset
//
// Configuration macro:
//   SAT_ACC_STICKY_OVF_EN - when defined, adds the ovf_sticky port and its
//                           register; otherwise both are absent.
// ---------------------------------------------------------------------------
module sat_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 6,
  parameter int N_SAMPLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_sat
`ifdef SAT_ACC_STICKY_OVF_EN
  ,
  output logic                 ovf_sticky
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
  localparam logic [7:0]           N_CNT   = 8'(N_SAMPLES);

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [7:0]           r_cnt;
  logic                 r_sat;

  logic                 w_accept;
  logic [WIDTH:0]       w_pair;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH:0]   w_sumWide;
  logic                 w_clamp;
  logic [ACC_WIDTH-1:0] w_accNext;
  logic [7:0]           w_cntNext;
  logic                 w_frameDone;

  // Handshake flags are pure decodes of the state register, so in_ready can
  // never combinationally depend on in_valid. The unused encoding reports
  // neither ready nor valid for its single cycle before recovering to idle.
  assign in_ready  = (r_state == S_IDLE) || (r_state == S_ACC);
  assign out_valid = (r_state == S_HOLD);
  assign out_sum   = r_acc;
  assign out_sat   = r_sat;

  // Datapath for the beat being offered. The first beat of a frame adds onto
  // zero rather than onto the stale accumulator, which starts the new frame.
  // With ACC_WIDTH >= WIDTH+1 the sum always fits in ACC_WIDTH+1 bits, so the
  // top bit alone tells us whether the result must clamp.
  always_comb begin
    w_accept    = in_valid & in_ready;
    w_pair      = {1'b0, in_a} + {1'b0, in_b};
    w_base      = (r_state == S_ACC) ? r_acc : '0;
    w_sumWide   = {1'b0, w_base} + (ACC_WIDTH+1)'(w_pair);
    w_clamp     = w_sumWide[ACC_WIDTH];
    w_accNext   = w_clamp ? ACC_MAX : w_sumWide[ACC_WIDTH-1:0];
    w_cntNext   = (r_state == S_ACC) ? (r_cnt + 8'd1) : 8'd1;
    w_frameDone = (w_cntNext == N_CNT);
  end

  // Frame controller. Reset wins over everything, including a result
  // handshake on the same edge. In HOLD the input side is closed, so the
  // edge that delivers the result can never also take the next first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= w_accNext;
            r_cnt   <= w_cntNext;
            r_sat   <= w_clamp;
            r_state <= w_frameDone ? S_HOLD : S_ACC;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_acc   <= w_accNext;
            r_cnt   <= w_cntNext;
            r_sat   <= r_sat | w_clamp;
            r_state <= w_frameDone ? S_HOLD : S_ACC;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SAT_ACC_STICKY_OVF_EN
  logic r_ovfSticky;

  // Records any clamp since reset, across frame boundaries; only reset
  // clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovfSticky <= 1'b0;
    end else if (w_accept && w_clamp) begin
      r_ovfSticky <= 1'b1;
    end
  end

  assign ovf_sticky = r_ovfSticky;
`endif

endmodule

// File: tb/tb_sat_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sat_accumulator
//
// Purpose:
//   Directed self-checking bench for sat_accumulator with WIDTH=4,
//   ACC_WIDTH=6, N_SAMPLES=4. Inputs are driven and outputs sampled on the
//   falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_sat_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_sum;
  logic       out_sat;
`ifdef SAT_ACC_STICKY_OVF_EN
  logic       ovf_sticky;
`endif

  int errors = 0;
  int checks = 0;

  sat_accumulator #(
    .WIDTH    (4),
    .ACC_WIDTH(6),
    .N_SAMPLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_sat  (out_sat)
`ifdef SAT_ACC_STICKY_OVF_EN
    ,
    .ovf_sticky(ovf_sticky)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Offers one beat for exactly one rising edge, returning at the next
  // falling edge with in_valid dropped.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Consumer takes the held result for one edge.
  task automatic takeResult();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Directed sequence; every expected value below is worked out by hand.
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    @(negedge clk);
    idleCycles(2);
    rst = 1'b0;

    // Reset state
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_sum", int'(out_sum), 0);
    checkOutput("reset out_sat", int'(out_sat), 0);
`ifdef SAT_ACC_STICKY_OVF_EN
    checkOutput("reset ovf_sticky", int'(ovf_sticky), 0);
`endif

    // Frame 1: 3, 10, 10, 20 with out_ready already high
    out_ready = 1'b1;
    applyStimulus(4'd1, 4'd2);
    applyStimulus(4'd3, 4'd4);
    applyStimulus(4'd0, 4'd0);
    checkOutput("f1 no early out_valid", int'(out_valid), 0);
    checkOutput("f1 in_ready mid-frame", int'(in_ready), 1);
    applyStimulus(4'd5, 4'd5);
    checkOutput("f1 out_valid latency", int'(out_valid), 1);
    checkOutput("f1 out_sum", int'(out_sum), 20);
    checkOutput("f1 out_sat", int'(out_sat), 0);
    checkOutput("f1 in_ready in hold", int'(in_ready), 0);
    idleCycles(1);
    checkOutput("f1 out_valid after take", int'(out_valid), 0);
    checkOutput("f1 in_ready after take", int'(in_ready), 1);
    out_ready = 1'b0;

    // Frame 2: (15,15) x4 -> 30, 60, 63 (clamp), 63 (clamp)
    for (int i = 0; i < 4; i++) applyStimulus(4'd15, 4'd15);
    checkOutput("f2 out_valid", int'(out_valid), 1);
    checkOutput("f2 out_sum", int'(out_sum), 63);
    checkOutput("f2 out_sat", int'(out_sat), 1);

    // Back-pressure in HOLD with beats offered: result stays put
    in_valid = 1'b1;
    in_a     = 4'd1;
    in_b     = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold out_valid", int'(out_valid), 1);
      checkOutput("hold out_sum", int'(out_sum), 63);
      checkOutput("hold out_sat", int'(out_sat), 1);
      checkOutput("hold in_ready", int'(in_ready), 0);
    end
    // Result taken with in_valid still high: that beat must not be counted
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("release out_valid", int'(out_valid), 0);
    checkOutput("release in_ready", int'(in_ready), 1);

    // Frame 3: (1,1) x4 -> 8, sat flag cleared for the new frame
    for (int i = 0; i < 4; i++) applyStimulus(4'd1, 4'd1);
    checkOutput("f3 out_valid", int'(out_valid), 1);
    checkOutput("f3 out_sum", int'(out_sum), 8);
    checkOutput("f3 out_sat", int'(out_sat), 0);
`ifdef SAT_ACC_STICKY_OVF_EN
    checkOutput("f3 ovf_sticky", int'(ovf_sticky), 1);
`endif
    takeResult();

    // Reset in the middle of a frame discards it
    applyStimulus(4'd7, 4'd7);
    applyStimulus(4'd7, 4'd7);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    checkOutput("midrst in_ready", int'(in_ready), 1);
    checkOutput("midrst out_valid", int'(out_valid), 0);
    checkOutput("midrst out_sum", int'(out_sum), 0);
`ifdef SAT_ACC_STICKY_OVF_EN
    checkOutput("midrst ovf_sticky", int'(ovf_sticky), 0);
`endif
    for (int i = 0; i < 4; i++) applyStimulus(4'd1, 4'd1);
    checkOutput("f4 out_valid", int'(out_valid), 1);
    checkOutput("f4 out_sum", int'(out_sum), 8);
    checkOutput("f4 out_sat", int'(out_sat), 0);
    takeResult();

    // Frame 5: (2,2) with 3 idle cycles between beats -> 16
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd2, 4'd2);
      if (i < 3) begin
        checkOutput("gap no out_valid", int'(out_valid), 0);
        idleCycles(3);
      end
    end
    checkOutput("f5 out_valid latency", int'(out_valid), 1);
    checkOutput("f5 out_sum", int'(out_sum), 16);
    checkOutput("f5 out_sat", int'(out_sat), 0);

    // Reset together with a result handshake: reset wins
    rst       = 1'b1;
    out_ready = 1'b1;
    idleCycles(1);
    rst       = 1'b0;
    out_ready = 1'b0;
    checkOutput("rst+take out_valid", int'(out_valid), 0);
    checkOutput("rst+take out_sum", int'(out_sum), 0);
    checkOutput("rst+take in_ready", int'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
